cpu_mem_bridge: RTL and testbench
=================================

Name: cpu_mem_bridge

Overview:
Sits directly downstream of the CPU's two memory ports (m_in read, m_out write). Converts byte-addressed, size-tagged request strobes into accesses on one synchronous word-wide SRAM port with byte enables. Returns read data right-justified, with zero upper bytes. Any halfword or word that crosses a 32-bit boundary is split into two SRAM accesses.

Parameters:
ADDR_WIDTH, 12, SRAM word-address width; the SRAM holds 2^ADDR_WIDTH words.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
m_in_sig_read  in  2  read request strobe, one cycle wide; 0=none, 1=byte, 2=half, 3=word
m_in_addr  in  32  read byte address; sampled when m_in_sig_read!=0
m_in_ready  out  1  one-cycle pulse: m_in_data is valid
m_in_data  out  32  read data, right-justified, zero-extended
m_out_sig_write  in  2  write request strobe; size encoding as for reads
m_out_addr  in  32  write byte address
m_out_data  in  32  write data; the low n bytes are used
m_out_ready  out  1  one-cycle pulse: write committed
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write (qualified by mem_en)
mem_addr  out  ADDR_WIDTH  SRAM word address
mem_be  out  4  byte enables; bit k = byte lane k
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data; valid the cycle after an edge where mem_en=1 and mem_we=0

Behaviour:
- Reset (reset_n low, any time, including mid-access):
  - all outputs 0; state IDLE; pending-write flag cleared.
  - No partial transaction resumes after release.
- Decode:
  - o = addr[1:0]; n = 1/2/4 bytes; word index w = addr[ADDR_WIDTH+1:2].
  - Split when o+n>4; the second access uses w+1 modulo 2^ADDR_WIDTH (wraps to word 0).
  - Upper address bits above ADDR_WIDTH+1 are ignored.
- Lanes:
  - 8-byte enable window = ((1<<n)-1)<<o; the low nibble goes to the first access, the high nibble to the second.
  - Write data is shifted left by 8*o across the same window.
  - Read: {second,first} is shifted right by 8*o, then masked to n bytes.
- States: IDLE, RD_A, RD_B, RD_RESP, WR_B, plus registered outputs.
- IDLE: requests are sampled at edge E0.
  - Read: at E0 drive mem_en=1, mem_we=0, mem_addr=w. Go to RD_B if split, else RD_RESP.
  - Write: at E0 drive mem_en=1, mem_we=1, mem_be=low nibble, mem_wdata=low word. If split, go to WR_B; else pulse m_out_ready at E1 and return to IDLE.
- RD_B: at E1 drive a second read of w+1; the first rdata is captured at E2.
- RD_RESP: at E2 (unsplit) or E3 (split):
  - load m_in_data, pulse m_in_ready for exactly one cycle;
  - mem_en=0; return to IDLE.
- WR_B: at E1 write w+1 with the high nibble; pulse m_out_ready at E2.
- Latency from the sampling edge to the ready edge:
  - read 2 cycles, split read 3;
  - write 1 cycle, split write 2.
- mem_en is low in every cycle the bridge is not accessing; m_in_data holds its value between reads.
- Simultaneous read and write strobes in IDLE:
  - The read is served first; the write (addr/data/size) is latched as pending.
  - The pending write starts the cycle after the m_in_ready pulse and completes normally.
- Strobes arriving while not IDLE are dropped (no ready is ever produced for them), except the pending-write capture above.
- A strobe arriving on the same edge as a ready pulse is also dropped: a request is accepted only in IDLE.

Decomposition:
- Shared package mem_bus_pkg:
  - size enum MEM_SZ_NONE=0, MEM_SZ_BYTE=1, MEM_SZ_HALF=2, MEM_SZ_WORD=3;
  - function size_bytes(sz) returning 1/2/4.
- One sub-module, mem_lane_shifter (combinational):
  - inputs: o, n, write data, the two read words;
  - outputs: 8-bit enable window, 64-bit shifted write data, aligned read result.
- The FSM, pending-write register and SRAM drive stay in cpu_mem_bridge.

Test Plan:
1. Preload word0=0x44332211, word1=0x88776655. Read byte @0x2 -> one mem_en; m_in_data=0x00000033; m_in_ready pulses 2 cycles after the sampling edge, for 1 cycle.
2. Same preload. Read word @0x3 -> mem_en for two consecutive cycles (addr 0 then 1); m_in_data=0x77665544; ready at +3.
3. Write half 0x0000BEEF @0x3 -> two writes:
   - addr 0: be=4'b1000, byte3=0xEF;
   - addr 1: be=4'b0001, byte0=0xBE.
   m_out_ready at +2. Readback word @0x0=0xEF332211, @0x4=0x887766BE.
4. Read word @0x0 and write word 0xCAFEF00D @0x8 in the same cycle -> read completes with 0xEF332211. Write starts the next cycle; m_out_ready follows 1 cycle later. Word 2 reads 0xCAFEF00D.
5. Read word @((2^ADDR_WIDTH-1)*4+2) -> second access at mem_addr=0. Result = {word0[15:0], wordTop[31:16]}.
6. Assert reset_n low between the two halves of a split write -> all outputs 0 at once; no m_out_ready. After release, IDLE accepts a byte read with normal 2-cycle latency.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus types for the CPU-to-SRAM bridge.
// Request size encoding, bridge states and size decode helper.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MEM_SZ_NONE = 2'd0,
    MEM_SZ_BYTE = 2'd1,
    MEM_SZ_HALF = 2'd2,
    MEM_SZ_WORD = 2'd3
  } mem_sz_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    RD_RESP,
    WR_B,
    WR_A
  } bridge_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      MEM_SZ_HALF: size_bytes = 3'd2;
      MEM_SZ_WORD: size_bytes = 3'd4;
      default:     size_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_shifter.sv
// Byte-lane steering between CPU-side right-justified data
// and the two SRAM words touched by a possibly split access.
module mem_lane_shifter (
  input  logic [1:0]  off,
  input  logic [2:0]  nbytes,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [7:0]  be_win,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata
);

  logic [5:0]  bit_off;
  logic [63:0] rd_sh;
  logic [31:0] mask;

  assign bit_off  = {off, 3'b000};
  assign be_win   = ((8'd1 << nbytes) - 8'd1) << off;
  assign wdata_sh = {32'd0, wdata} << bit_off;
  assign rd_sh    = {rd_hi, rd_lo} >> bit_off;

  always_comb begin
    mask = 32'hffff_ffff;
    case (nbytes)
      3'd1:    mask = 32'h0000_00ff;
      3'd2:    mask = 32'h0000_ffff;
      default: mask = 32'hffff_ffff;
    endcase
  end

  assign rdata = rd_sh[31:0] & mask;

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges the CPU byte-addressed read/write strobes onto one
// word-wide synchronous SRAM port, splitting unaligned accesses.
module cpu_mem_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            m_in_sig_read,
  input  logic [31:0]           m_in_addr,
  output logic                  m_in_ready,
  output logic [31:0]           m_in_data,
  input  logic [1:0]            m_out_sig_write,
  input  logic [31:0]           m_out_addr,
  input  logic [31:0]           m_out_data,
  output logic                  m_out_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int AW = ADDR_WIDTH;

  bridge_state_e state, state_d;

  logic [1:0]    req_off, req_off_d;
  logic [1:0]    req_sz, req_sz_d;
  logic [AW-1:0] req_word, req_word_d;
  logic          req_split, req_split_d;
  logic [3:0]    hi_be, hi_be_d;
  logic [31:0]   hi_wdata, hi_wdata_d;
  logic [31:0]   cap, cap_d;

  logic          pend_v, pend_v_d;
  logic [AW+1:0] pend_addr, pend_addr_d;
  logic [1:0]    pend_sz, pend_sz_d;
  logic [31:0]   pend_data, pend_data_d;

  logic          in_ready_d, out_ready_d;
  logic [31:0]   in_data_d;
  logic          mem_en_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [3:0]    mem_be_d;
  logic [31:0]   mem_wdata_d;

  logic          rd_req, wr_req;
  logic [1:0]    a_off, a_sz;
  logic [AW-1:0] a_word;
  logic [31:0]   a_wdata;
  logic [2:0]    a_n;
  logic          a_split;
  logic [7:0]    win;
  logic [63:0]   wsh;
  logic [31:0]   rres;
  logic          unused_hi;

  assign rd_req = m_in_sig_read != 2'd0;
  assign wr_req = m_out_sig_write != 2'd0;
  assign unused_hi = ^{m_in_addr[31:AW+2], m_out_addr[31:AW+2]};

  // In IDLE the shifter sees the request being accepted,
  // otherwise the latched one.
  always_comb begin
    a_off   = req_off;
    a_sz    = req_sz;
    a_word  = req_word;
    a_wdata = pend_data;
    if (state == IDLE) begin
      if (pend_v) begin
        a_off   = pend_addr[1:0];
        a_sz    = pend_sz;
        a_word  = pend_addr[AW+1:2];
        a_wdata = pend_data;
      end else if (rd_req) begin
        a_off  = m_in_addr[1:0];
        a_sz   = m_in_sig_read;
        a_word = m_in_addr[AW+1:2];
      end else begin
        a_off   = m_out_addr[1:0];
        a_sz    = m_out_sig_write;
        a_word  = m_out_addr[AW+1:2];
        a_wdata = m_out_data;
      end
    end
  end

  assign a_n     = size_bytes(a_sz);
  assign a_split = ({1'b0, a_off} + a_n) > 3'd4;

  mem_lane_shifter u_shift (
    .off      (a_off),
    .nbytes   (a_n),
    .wdata    (a_wdata),
    .rd_lo    (req_split ? cap : mem_rdata),
    .rd_hi    (mem_rdata),
    .be_win   (win),
    .wdata_sh (wsh),
    .rdata    (rres)
  );

  always_comb begin
    state_d     = state;
    req_off_d   = req_off;
    req_sz_d    = req_sz;
    req_word_d  = req_word;
    req_split_d = req_split;
    hi_be_d     = hi_be;
    hi_wdata_d  = hi_wdata;
    cap_d       = cap;
    pend_v_d    = pend_v;
    pend_addr_d = pend_addr;
    pend_sz_d   = pend_sz;
    pend_data_d = pend_data;
    in_ready_d  = 1'b0;
    out_ready_d = 1'b0;
    in_data_d   = m_in_data;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_be_d    = 4'd0;
    mem_wdata_d = mem_wdata;
    unique case (state)
      IDLE: begin
        if (pend_v || rd_req || wr_req) begin
          req_off_d   = a_off;
          req_sz_d    = a_sz;
          req_word_d  = a_word;
          req_split_d = a_split;
          hi_be_d     = win[7:4];
          hi_wdata_d  = wsh[63:32];
          mem_en_d    = 1'b1;
          mem_addr_d  = a_word;
          if (!pend_v && rd_req) begin
            mem_be_d = 4'hf;
            state_d  = a_split ? RD_B : RD_A;
            // a write arriving with the read waits its turn
            if (wr_req) begin
              pend_v_d    = 1'b1;
              pend_addr_d = m_out_addr[AW+1:0];
              pend_sz_d   = m_out_sig_write;
              pend_data_d = m_out_data;
            end
          end else begin
            mem_we_d    = 1'b1;
            mem_be_d    = win[3:0];
            mem_wdata_d = wsh[31:0];
            pend_v_d    = 1'b0;
            state_d     = a_split ? WR_B : WR_A;
          end
        end
      end
      RD_B: begin
        mem_en_d   = 1'b1;
        mem_be_d   = 4'hf;
        mem_addr_d = req_word + 1'b1;
        state_d    = RD_A;
      end
      RD_A: begin
        cap_d   = mem_rdata;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        in_data_d  = rres;
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
      WR_B: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = req_word + 1'b1;
        mem_be_d    = hi_be;
        mem_wdata_d = hi_wdata;
        state_d     = WR_A;
      end
      WR_A: begin
        out_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_off     <= '0;
      req_sz      <= '0;
      req_word    <= '0;
      req_split   <= 1'b0;
      hi_be       <= '0;
      hi_wdata    <= '0;
      cap         <= '0;
      pend_v      <= 1'b0;
      pend_addr   <= '0;
      pend_sz     <= '0;
      pend_data   <= '0;
      m_in_ready  <= 1'b0;
      m_in_data   <= '0;
      m_out_ready <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_d;
      req_off     <= req_off_d;
      req_sz      <= req_sz_d;
      req_word    <= req_word_d;
      req_split   <= req_split_d;
      hi_be       <= hi_be_d;
      hi_wdata    <= hi_wdata_d;
      cap         <= cap_d;
      pend_v      <= pend_v_d;
      pend_addr   <= pend_addr_d;
      pend_sz     <= pend_sz_d;
      pend_data   <= pend_data_d;
      m_in_ready  <= in_ready_d;
      m_in_data   <= in_data_d;
      m_out_ready <= out_ready_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_be      <= mem_be_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: SRAM model, byte-array reference,
// directed vector table, corner sequences and random traffic.
module tb_cpu_mem_bridge;

  localparam int AW     = 12;
  localparam int DEPTH  = 1 << AW;
  localparam int NBYTES = DEPTH * 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [1:0]    m_in_sig_read = '0;
  logic [31:0]   m_in_addr = '0;
  logic          m_in_ready;
  logic [31:0]   m_in_data;
  logic [1:0]    m_out_sig_write = '0;
  logic [31:0]   m_out_addr = '0;
  logic [31:0]   m_out_data = '0;
  logic          m_out_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  cpu_mem_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m_in_sig_read   (m_in_sig_read),
    .m_in_addr       (m_in_addr),
    .m_in_ready      (m_in_ready),
    .m_in_data       (m_in_data),
    .m_out_sig_write (m_out_sig_write),
    .m_out_addr      (m_out_addr),
    .m_out_data      (m_out_data),
    .m_out_ready     (m_out_ready),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  logic [31:0] sram [DEPTH];
  logic [7:0]  ref_mem [NBYTES];

  int n_chk = 0;
  int n_fail = 0;

  int            en_cnt, rdy_in_cnt, rdy_out_cnt;
  logic [AW-1:0] en_addr [$];
  logic [3:0]    en_be [$];
  logic [31:0]   en_wd [$];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) sram[mem_addr][8*k +: 8] = mem_wdata[8*k +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      en_cnt++;
      en_addr.push_back(mem_addr);
      en_be.push_back(mem_be);
      en_wd.push_back(mem_wdata);
    end
    if (m_in_ready) rdy_in_cnt++;
    if (m_out_ready) rdy_out_cnt++;
  end

  task automatic clr_mon();
    en_cnt = 0;
    rdy_in_cnt = 0;
    rdy_out_cnt = 0;
    en_addr.delete();
    en_be.delete();
    en_wd.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] sz);
    case (sz)
      2'd1:    return 1;
      2'd2:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit split_of(input logic [31:0] a, input logic [1:0] sz);
    return (int'(a[1:0]) + nb(sz)) > 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a,
                                           input logic [1:0] sz);
    logic [31:0] r;
    int base;
    r = '0;
    base = int'(a[AW+1:0]);
    for (int k = 0; k < nb(sz); k++) r[8*k +: 8] = ref_mem[(base + k) % NBYTES];
    return r;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d);
    int base;
    base = int'(a[AW+1:0]);
    for (int k = 0; k < nb(sz); k++) ref_mem[(base + k) % NBYTES] = d[8*k +: 8];
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    sram[w] = v;
    for (int k = 0; k < 4; k++) ref_mem[4*w + k] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] bemask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  function automatic logic [31:0] q_addr(input int i);
    return (en_addr.size() > i) ? 32'(en_addr[i]) : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] q_be(input int i);
    return (en_be.size() > i) ? 32'(en_be[i]) : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] q_wd(input int i);
    return (en_wd.size() > i) ? en_wd[i] : 32'hffff_ffff;
  endfunction

  task automatic do_op(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d, output logic [31:0] rd,
                       output int lat);
    @(negedge clk);
    clr_mon();
    if (wr) begin
      m_out_sig_write = sz;
      m_out_addr = a;
      m_out_data = d;
    end else begin
      m_in_sig_read = sz;
      m_in_addr = a;
    end
    @(posedge clk);
    #1;
    m_in_sig_read = '0;
    m_out_sig_write = '0;
    lat = -1;
    rd = '0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && (wr ? m_out_ready : m_in_ready)) begin
        lat = i;
        rd = m_in_data;
      end
    end
  endtask

  task automatic run_op(input string tag, input bit wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit lanes,
                        input logic [3:0] be0, input logic [3:0] be1,
                        input logic [31:0] wd0, input logic [31:0] wd1);
    logic [31:0] rd, held;
    int lat, w;
    bit sp;
    sp = split_of(a, sz);
    w = int'(a[AW+1:2]);
    held = m_in_data;
    do_op(wr, a, sz, d, rd, lat);
    check({tag, " latency"}, lat, wr ? (sp ? 2 : 1) : (sp ? 3 : 2));
    check({tag, " mem_en cycles"}, en_cnt, sp ? 2 : 1);
    check({tag, " ready pulses"}, wr ? rdy_out_cnt : rdy_in_cnt, 1);
    check({tag, " addr0"}, q_addr(0), w);
    if (sp) check({tag, " addr1"}, q_addr(1), (w + 1) % DEPTH);
    if (wr) begin
      ref_write(a, sz, d);
      check({tag, " m_in_data held"}, m_in_data, held);
      if (lanes) begin
        check({tag, " be0"}, q_be(0), 32'(be0));
        check({tag, " wd0"}, q_wd(0) & bemask(be0), wd0 & bemask(be0));
        if (sp) begin
          check({tag, " be1"}, q_be(1), 32'(be1));
          check({tag, " wd1"}, q_wd(1) & bemask(be1), wd1 & bemask(be1));
        end
      end
    end else begin
      check({tag, " data"}, rd, exp_rd);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] wd0;
    logic [31:0] wd1;
  } vec_t;

  vec_t vt [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdv, a, d;
    logic [1:0]  sz;
    int ri, wi, wei;
    logic [31:0] wea;

    vt[0]  = '{0, 2'd1, 32'h0000_0002, 32'h0, 32'h0000_0033, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[1]  = '{0, 2'd3, 32'h0000_0003, 32'h0, 32'h7766_5544, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[2]  = '{1, 2'd2, 32'h0000_0003, 32'h0000_BEEF, 32'h0, 4'b1000, 4'b0001,
               32'hEF00_0000, 32'h0000_00BE};
    vt[3]  = '{0, 2'd3, 32'h0000_0000, 32'h0, 32'hEF33_2211, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[4]  = '{0, 2'd3, 32'h0000_0004, 32'h0, 32'h8877_66BE, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[5]  = '{0, 2'd2, 32'h0000_0001, 32'h0, 32'h0000_3322, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[6]  = '{0, 2'd2, 32'h0000_0003, 32'h0, 32'h0000_BEEF, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[7]  = '{1, 2'd1, 32'h0000_0005, 32'h1234_56A5, 32'h0, 4'b0010, 4'h0,
               32'h0000_A500, 32'h0};
    vt[8]  = '{0, 2'd3, 32'h0000_0004, 32'h0, 32'h8877_A5BE, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[9]  = '{1, 2'd3, 32'h0000_0006, 32'h0102_0304, 32'h0, 4'b1100, 4'b0011,
               32'h0304_0000, 32'h0000_0102};
    vt[10] = '{0, 2'd3, 32'h0000_0004, 32'h0, 32'h0304_A5BE, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[11] = '{0, 2'd3, 32'h0000_0008, 32'h0, 32'h0000_0102, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[12] = '{0, 2'd2, 32'h0000_0006, 32'h0, 32'h0000_0304, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[13] = '{0, 2'd1, 32'hFFFF_C009, 32'h0, 32'h0000_0001, 4'h0, 4'h0, 32'h0, 32'h0};
    vt[14] = '{0, 2'd3, 32'h0000_0001, 32'h0, 32'hBEEF_3322, 4'h0, 4'h0, 32'h0, 32'h0};

    for (int i = 0; i < DEPTH; i++) preload(i, 32'h0);
    preload(0, 32'h4433_2211);
    preload(1, 32'h8877_6655);

    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs",
          {31'd0, m_in_ready | m_out_ready | mem_en | mem_we},
          32'd0);
    check("reset bus", {20'd0, mem_addr} | 32'(mem_be) | mem_wdata | m_in_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].sz, vt[i].wd,
             vt[i].exp, 1'b1, vt[i].be0, vt[i].be1, vt[i].wd0, vt[i].wd1);

    // read and write strobed together: read first, write after ready
    @(negedge clk);
    clr_mon();
    m_in_sig_read = 2'd3;
    m_in_addr = 32'h0;
    m_out_sig_write = 2'd3;
    m_out_addr = 32'h8;
    m_out_data = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    m_in_sig_read = '0;
    m_out_sig_write = '0;
    ri = -1; wi = -1; wei = -1; wea = '0; rdv = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (ri < 0 && m_in_ready) begin ri = i; rdv = m_in_data; end
      if (wi < 0 && m_out_ready) wi = i;
      if (wei < 0 && mem_en && mem_we) begin wei = i; wea = 32'(mem_addr); end
    end
    check("simul read latency", ri, 2);
    check("simul read data", rdv, 32'hEF33_2211);
    check("simul write start", wei, 3);
    check("simul write addr", wea, 32'd2);
    check("simul write ready", wi, 4);
    check("simul ready counts", {rdy_in_cnt[15:0], rdy_out_cnt[15:0]}, 32'h0001_0001);
    ref_write(32'h8, 2'd3, 32'hCAFE_F00D);
    run_op("simul readback", 0, 32'h8, 2'd3, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0);

    // strobes while busy and on the ready edge are dropped
    @(negedge clk);
    clr_mon();
    m_in_sig_read = 2'd3;
    m_in_addr = 32'h3;
    @(posedge clk);
    #1 m_in_sig_read = '0;
    @(negedge clk);
    m_out_sig_write = 2'd3;
    m_out_addr = 32'h10;
    m_out_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 m_out_sig_write = '0;
    @(posedge clk);
    @(negedge clk);
    m_in_sig_read = 2'd1;
    m_in_addr = 32'h0;
    @(posedge clk);
    #1;
    m_in_sig_read = '0;
    check("busy read ready", {31'd0, m_in_ready}, 32'd1);
    check("busy read data", m_in_data, ref_read(32'h3, 2'd3));
    repeat (6) @(posedge clk);
    #1;
    check("dropped read", rdy_in_cnt, 1);
    check("dropped write", rdy_out_cnt, 0);
    check("dropped accesses", en_cnt, 2);
    run_op("dropped readback", 0, 32'h10, 2'd3, 0, ref_read(32'h10, 2'd3),
           0, 0, 0, 0, 0);

    // split read wrapping from the top word to word 0
    preload(DEPTH - 1, 32'hDDCC_BBAA);
    run_op("wrap", 0, 32'h8000_0000 | 32'((DEPTH - 1) * 4 + 2), 2'd3, 0,
           32'h2211_DDCC, 0, 0, 0, 0, 0);

    // reset between the halves of a split write
    @(negedge clk);
    clr_mon();
    m_out_sig_write = 2'd2;
    m_out_addr = 32'h7;
    m_out_data = 32'h0000_5A5A;
    @(posedge clk);
    #1;
    m_out_sig_write = '0;
    check("pre-reset mem_en", {31'd0, mem_en}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid reset outputs",
          {31'd0, m_in_ready | m_out_ready | mem_en | mem_we},
          32'd0);
    check("mid reset bus", {20'd0, mem_addr} | 32'(mem_be) | mem_wdata | m_in_data, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no ready after reset", rdy_out_cnt + rdy_in_cnt, 0);
    run_op("post reset read", 0, 32'h2, 2'd1, 0, 32'h0000_0033, 0, 0, 0, 0, 0);

    // random traffic against the byte-array reference
    for (int i = 0; i < 150; i++) begin
      int w;
      w = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7))
                                      : DEPTH - 1 - int'($urandom_range(0, 3));
      sz = 2'($urandom_range(1, 3));
      a = ($urandom << (AW + 2)) | (32'(w) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      run_op("rnd", $urandom_range(0, 1) != 0, a, sz, d, ref_read(a, sz),
             0, 0, 0, 0, 0);
    end
    for (int w = 0; w < 8; w++)
      run_op("sweep lo", 0, 32'(w * 4), 2'd3, 0, ref_read(32'(w * 4), 2'd3),
             0, 0, 0, 0, 0);
    for (int w = DEPTH - 4; w < DEPTH; w++)
      run_op("sweep hi", 0, 32'(w * 4), 2'd3, 0, ref_read(32'(w * 4), 2'd3),
             0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
